// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Optional feature macro: MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU
// accumulate ops; without it codes 9..12 behave as NONE.
package mdu_sequencer_pkg;

    localparam int unsigned MDU_OP_SIZE = 4;

    typedef enum logic [MDU_OP_SIZE-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } mdu_state_e;

    function automatic logic is_div_op(input logic [MDU_OP_SIZE-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_madd_op(input logic [MDU_OP_SIZE-1:0] op);
`ifdef MDU_MADD_EN
        return (op == MDU_MADD) || (op == MDU_MADDU) ||
               (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
        return (op == MDU_NONE) && (op != MDU_NONE);
`endif
    endfunction

    // Ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_md_op(input logic [MDU_OP_SIZE-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || is_div_op(op) || is_madd_op(op);
    endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational datapath: 64-bit {HI,LO} result for mult/div (and the
// accumulate family when MDU_MADD_EN is defined) plus a divide-by-zero flag.
module mdu_compute
    import mdu_sequencer_pkg::*;
(
    input  logic [MDU_OP_SIZE-1:0] op_i,
    input  logic [31:0]            rs_i,
    input  logic [31:0]            rt_i,
    input  logic [31:0]            hi_i,
    input  logic [31:0]            lo_i,
    output logic [63:0]            result_o,
    output logic                   div_zero_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn_a;
    logic        sgn_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

`ifndef MDU_MADD_EN
    logic unused_acc;
    assign unused_acc = ^{hi_i, lo_i};
`endif

    // Division works on magnitudes so truncation toward zero and the
    // dividend-signed remainder fall out directly, including 0x80000000/-1.
    always_comb begin
        prod_s  = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
        prod_u  = {32'd0, rs_i} * {32'd0, rt_i};
        sgn_a   = (op_i == MDU_DIV) && rs_i[31];
        sgn_b   = (op_i == MDU_DIV) && rt_i[31];
        mag_a   = sgn_a ? (32'd0 - rs_i) : rs_i;
        mag_b   = sgn_b ? (32'd0 - rt_i) : rt_i;
        if (mag_b == '0) begin
            mag_b = 32'd1;
        end
        quo_mag = mag_a / mag_b;
        rem_mag = mag_a % mag_b;
        quo     = (sgn_a ^ sgn_b) ? (32'd0 - quo_mag) : quo_mag;
        rem     = sgn_a ? (32'd0 - rem_mag) : rem_mag;

        div_zero_o = is_div_op(op_i) && (rt_i == '0);
        case (op_i)
            MDU_MULT:  result_o = prod_s;
            MDU_MULTU: result_o = prod_u;
            MDU_DIV,
            MDU_DIVU:  result_o = {rem, quo};
`ifdef MDU_MADD_EN
            MDU_MADD:  result_o = {hi_i, lo_i} + prod_s;
            MDU_MADDU: result_o = {hi_i, lo_i} + prod_u;
            MDU_MSUB:  result_o = {hi_i, lo_i} - prod_s;
            MDU_MSUBU: result_o = {hi_i, lo_i} - prod_u;
`endif
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide unit: owns HI/LO, sequences mult/div latency and
// drives the busy flag used by hazard control. Optional feature macro:
// MDU_MADD_EN (accumulate ops MADD/MADDU/MSUB/MSUBU).
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,   // legal 1..15
    parameter int unsigned DIV_CYCLES  = 10   // legal 1..15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MDU_OP_SIZE-1:0] op,
    input  logic [31:0]            rs_data,
    input  logic [31:0]            rt_data,
    input  logic                   cancel,
    output logic                   busy,
    output logic [31:0]            out
);

    mdu_state_e  state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi_q;
    logic [31:0] pend_lo_q;
    logic        pend_dz_q;
    logic        start_md;
    logic [63:0] result;
    logic        div_zero;

    mdu_compute u_compute (
        .op_i       (op),
        .rs_i       (rs_data),
        .rt_i       (rt_data),
        .hi_i       (hi_q),
        .lo_i       (lo_q),
        .result_o   (result),
        .div_zero_o (div_zero)
    );

    assign start_md = (state_q == ST_IDLE) && is_md_op(op);

    // Sequencer: launch from IDLE, count down in BUSY, commit pend on 1->0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_dz_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!cancel) begin
                        if (start_md) begin
                            pend_hi_q <= result[63:32];
                            pend_lo_q <= result[31:0];
                            pend_dz_q <= div_zero;
                            cnt_q     <= is_div_op(op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            state_q   <= ST_BUSY;
                        end else if (op == MDU_MTHI) begin
                            hi_q <= rs_data;
                        end else if (op == MDU_MTLO) begin
                            lo_q <= rs_data;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_IDLE;
                        if (!pend_dz_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Busy covers the launch cycle combinationally so the stall is immediate.
    always_comb begin
        busy = (cnt_q != '0) || (start_md && !cancel);
    end

    // HI/LO read port.
    always_comb begin
        case (op)
            MDU_MFHI: out = hi_q;
            MDU_MFLO: out = lo_q;
            default:  out = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: the driver queues the expected busy/out
// for each cycle it drives, and a negedge monitor pops and compares.
module tb_mdu_sequencer;

    localparam int unsigned M = 5;
    localparam int unsigned D = 10;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTHI  = 4'd7;
    localparam logic [3:0] MTLO  = 4'd8;
    localparam logic [3:0] MADD  = 4'd9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  op = NONE;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        busy;
        logic [31:0] out;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mdu_sequencer #(
        .MULT_CYCLES (M),
        .DIV_CYCLES  (D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .cancel  (cancel),
        .busy    (busy),
        .out     (out)
    );

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL %s busy got %0b exp %0b", e.name, busy, e.busy);
            end
            checks++;
            if (out !== e.out) begin
                errors++;
                $display("FAIL %s out got %h exp %h", e.name, out, e.out);
            end
        end
    end

    task automatic step(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic r, input logic eb,
                        input logic [31:0] eo, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        op = o; rs_data = a; rt_data = b; cancel = c; reset = r;
        e.busy = eb; e.out = eo; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle(input int unsigned n, input logic eb, input string nm);
        for (int unsigned i = 0; i < n; i++) step(NONE, '0, '0, 1'b0, 1'b0, eb, '0, nm);
    endtask

    initial begin
        step(NONE, '0, '0, 0, 1, 0, '0, "reset0");
        step(MFHI, '0, '0, 0, 1, 0, '0, "reset_hi");
        step(MFLO, '0, '0, 0, 0, 0, '0, "reset_lo");

        step(MULT, 32'hFFFFFFFE, 32'd3, 0, 0, 1, '0, "mult_start");
        idle(M, 1, "mult_busy");
        step(MFHI, '0, '0, 0, 0, 0, 32'hFFFFFFFF, "mult_hi");
        step(MFLO, '0, '0, 0, 0, 0, 32'hFFFFFFFA, "mult_lo");

        step(MULTU, 32'hFFFFFFFF, 32'd2, 0, 0, 1, '0, "multu_start");
        idle(M, 1, "multu_busy");
        step(MFHI, '0, '0, 0, 0, 0, 32'd1, "multu_hi");
        step(MFLO, '0, '0, 0, 0, 0, 32'hFFFFFFFE, "multu_lo");

        step(DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 1, '0, "div_start");
        idle(D, 1, "div_busy");
        step(MFLO, '0, '0, 0, 0, 0, 32'hFFFFFFFD, "div_lo");
        step(MFHI, '0, '0, 0, 0, 0, 32'hFFFFFFFF, "div_hi");

        step(DIVU, 32'd7, 32'd0, 0, 0, 1, '0, "divz_start");
        idle(D, 1, "divz_busy");
        step(MFHI, '0, '0, 0, 0, 0, 32'hFFFFFFFF, "divz_hi");
        step(MFLO, '0, '0, 0, 0, 0, 32'hFFFFFFFD, "divz_lo");

        step(MULTU, 32'd3, 32'd4, 0, 0, 1, '0, "ign_start");
        step(MTHI, 32'hDEAD, '0, 0, 0, 1, '0, "ign_mthi");
        idle(M - 1, 1, "ign_busy");
        step(MFHI, '0, '0, 0, 0, 0, 32'd0, "ign_hi");
        step(MFLO, '0, '0, 0, 0, 0, 32'd12, "ign_lo");

        step(DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, '0, "ovf_start");
        idle(D, 1, "ovf_busy");
        step(MFLO, '0, '0, 0, 0, 0, 32'h80000000, "ovf_lo");
        step(MFHI, '0, '0, 0, 0, 0, 32'd0, "ovf_hi");

        step(MTHI, 32'h1234, '0, 1, 0, 0, '0, "mthi_cancel");
        step(MFHI, '0, '0, 0, 0, 0, 32'd0, "mthi_cancel_hi");
        step(MTHI, 32'h1234, '0, 0, 0, 0, '0, "mthi");
        step(MFHI, '0, '0, 0, 0, 0, 32'h1234, "mthi_hi");
        step(MTLO, 32'h55, '0, 0, 0, 0, '0, "mtlo");
        step(MFLO, '0, '0, 0, 0, 0, 32'h55, "mtlo_lo");
        step(MULT, 32'd5, 32'd5, 1, 0, 0, '0, "mult_cancel");
        step(MFLO, '0, '0, 0, 0, 0, 32'h55, "mult_cancel_lo");
        step(4'd13, 32'd5, 32'd5, 0, 0, 0, '0, "op13");
        step(MFHI, '0, '0, 0, 0, 0, 32'h1234, "op13_hi");

        step(MULT, 32'd2, 32'd3, 0, 0, 1, '0, "cbusy_start");
        step(NONE, '0, '0, 1, 0, 1, '0, "cbusy_cancel");
        idle(M - 1, 1, "cbusy_busy");
        step(MFLO, '0, '0, 0, 0, 0, 32'd6, "cbusy_lo");
        step(MFHI, '0, '0, 0, 0, 0, 32'd0, "cbusy_hi");

        step(DIV, 32'd100, 32'd7, 0, 0, 1, '0, "rst_start");
        idle(6, 1, "rst_busy");
        step(NONE, '0, '0, 0, 1, 1, '0, "rst_pulse");
        idle(D, 0, "rst_abort");
        step(MFHI, '0, '0, 0, 0, 0, 32'd0, "rst_hi");
        step(MFLO, '0, '0, 0, 0, 0, 32'd0, "rst_lo");

        step(MTHI, 32'd0, '0, 0, 0, 0, '0, "madd_sethi");
        step(MTLO, 32'hFFFFFFFF, '0, 0, 0, 0, '0, "madd_setlo");
`ifdef MDU_MADD_EN
        step(MADD, 32'd1, 32'd1, 0, 0, 1, '0, "madd_start");
        idle(M, 1, "madd_busy");
        step(MFHI, '0, '0, 0, 0, 0, 32'd1, "madd_hi");
        step(MFLO, '0, '0, 0, 0, 0, 32'd0, "madd_lo");
`else
        step(MADD, 32'd1, 32'd1, 0, 0, 0, '0, "madd_start");
        idle(M, 0, "madd_idle");
        step(MFHI, '0, '0, 0, 0, 0, 32'd0, "madd_hi");
        step(MFLO, '0, '0, 0, 0, 0, 32'hFFFFFFFF, "madd_lo");
`endif

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
